// File: rtl/snitch_pkg.sv
// rtl/snitch_pkg.sv - shared types and register map for the cluster performance counters
package snitch_pkg;

    // Per-hart event strobes, one bit per event type (bit 3 = retired_instr)
    typedef struct packed {
        logic issue_fpu;
        logic issue_core_to_fpu;
        logic issue_fpu_seq;
        logic retired_instr;
        logic retired_load;
        logic retired_i;
        logic retired_acc;
    } core_events_t;

    typedef enum logic {
        PerfWrap = 1'b0,
        PerfSat  = 1'b1
    } perf_mode_e;

    // CTRL register layout: bit0 enable, bit1 mode
    typedef struct packed {
        perf_mode_e mode;
        logic       enable;
    } perf_ctrl_t;

    // Per-counter selection: hart mask bits 0..23 and event index
    typedef struct packed {
        logic [23:0] hart_mask;
        logic [3:0]  evt;
    } perf_sel_t;

    localparam logic [3:0] PerfCtrlOff    = 4'h0;
    localparam logic [3:0] PerfSelOff     = 4'h4;
    localparam logic [3:0] PerfLoOff      = 4'h8;
    localparam logic [3:0] PerfHiOff      = 4'hC;
    localparam logic [7:0] PerfOvfAddr    = 8'hF0;
    localparam logic [7:0] PerfIrqEnAddr  = 8'hF4;
    localparam logic [7:0] PerfMaskHiAddr = 8'hF8;

    // Bitmask of harts that exist; mask bits above this read back as zero
    function automatic logic [31:0] perf_hart_valid(input int unsigned num_cores);
        logic [63:0] m;
        m = (64'd1 << num_cores) - 64'd1;
        return m[31:0];
    endfunction

endpackage

// File: rtl/snitch_perf_counter.sv
// rtl/snitch_perf_counter.sv - one event counter with wrap/saturate modes and a coherent high-word shadow
module snitch_perf_counter import snitch_pkg::*; #(
    parameter int unsigned Width = 48,
    parameter int unsigned IncW  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  perf_ctrl_t        ctrl_i,
    input  logic [IncW-1:0]   incr_i,
    input  logic              wr_lo_i,
    input  logic              wr_hi_i,
    input  logic [31:0]       wdata_i,
    input  logic              snap_i,
    output logic [31:0]       value_lo_o,
    output logic [Width-33:0] shadow_o,
    output logic              ovf_o
);

    localparam int unsigned HiW = Width - 32;

    logic [Width-1:0] value_q, value_d;
    logic [HiW-1:0]   shadow_q;
    logic [Width:0]   sum;

    // Candidate sum with an extra bit to expose the carry-out
    always_comb begin
        sum = {1'b0, value_q} + {{(Width + 1 - IncW){1'b0}}, incr_i};
    end

    // Next value: software writes take priority and drop that cycle's increment
    always_comb begin
        value_d = value_q;
        ovf_o   = 1'b0;
        if (wr_lo_i) begin
            value_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            value_d[Width-1:32] = wdata_i[HiW-1:0];
        end else if (ctrl_i.enable) begin
            if (sum[Width]) begin
                ovf_o   = 1'b1;
                value_d = (ctrl_i.mode == PerfSat) ? {Width{1'b1}} : sum[Width-1:0];
            end else begin
                value_d = sum[Width-1:0];
            end
        end
    end

    // Counter value and the high-word shadow captured on low-word reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q  <= '0;
            shadow_q <= '0;
        end else begin
            value_q <= value_d;
            if (snap_i) begin
                shadow_q <= value_q[Width-1:32];
            end
        end
    end

    assign value_lo_o = value_q[31:0];
    assign shadow_o   = shadow_q;

endmodule

// File: rtl/snitch_perf_counters.sv
// rtl/snitch_perf_counters.sv - cluster performance counter unit with register request/response port
module snitch_perf_counters import snitch_pkg::*; #(
    parameter int unsigned NumCores     = 8,
    parameter int unsigned NumCounters  = 4,
    parameter int unsigned CounterWidth = 48,
    parameter int unsigned NumEvents    = $bits(core_events_t)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumCores*NumEvents-1:0] core_events_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_write_i,
    input  logic [7:0]                    req_addr_i,
    input  logic [31:0]                   req_wdata_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [31:0]                   rsp_rdata_o,
    output logic                          rsp_error_o,
    output logic                          irq_o
);

    localparam int unsigned IncW      = $clog2(NumCores + 1);
    localparam int unsigned HiW       = CounterWidth - 32;
    localparam logic [31:0] HartValid = perf_hart_valid(NumCores);

    logic [NumCores*NumEvents-1:0] events_q;

    perf_ctrl_t [NumCounters-1:0] ctrl_q;
    perf_sel_t  [NumCounters-1:0] sel_q;
    logic [7:0]                   mask_hi_q;
    logic [NumCounters-1:0]       ovf_q, ovf_d, ovf_set, irq_en_q;
    logic                         irq_q;

    logic        rsp_valid_q, rsp_error_q;
    logic [31:0] rsp_rdata_q;

    logic [NumCounters-1:0][IncW-1:0] incr;
    logic [NumCounters-1:0][31:0]     value_lo;
    logic [NumCounters-1:0][HiW-1:0]  shadow;

    logic                   accept, wr, rd;
    logic [3:0]             ctr_idx, ctr_off;
    logic                   is_global, ctr_hit;
    logic [31:0]            rdata;
    logic                   error;
    logic [NumCounters-1:0] wr_ctrl, wr_sel, wr_lo, wr_hi, snap;
    logic                   wr_ovf, wr_irq_en, wr_mask_hi;

    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign wr          = accept && req_write_i;
    assign rd          = accept && !req_write_i;
    assign ctr_idx     = req_addr_i[7:4];
    assign ctr_off     = req_addr_i[3:0];
    assign is_global   = (ctr_idx == 4'hF);
    assign ctr_hit     = !is_global && (32'(ctr_idx) < NumCounters);

    // Address decode: read data, error flag and per-register write strobes
    always_comb begin
        rdata      = '0;
        error      = 1'b0;
        wr_ctrl    = '0;
        wr_sel     = '0;
        wr_lo      = '0;
        wr_hi      = '0;
        snap       = '0;
        wr_ovf     = 1'b0;
        wr_irq_en  = 1'b0;
        wr_mask_hi = 1'b0;
        if (req_addr_i[1:0] != 2'b00) begin
            error = 1'b1;
        end else if (is_global) begin
            case (req_addr_i)
                PerfOvfAddr: begin
                    rdata  = 32'(ovf_q);
                    wr_ovf = wr;
                end
                PerfIrqEnAddr: begin
                    rdata     = 32'(irq_en_q);
                    wr_irq_en = wr;
                end
                PerfMaskHiAddr: begin
                    rdata      = {24'b0, mask_hi_q};
                    wr_mask_hi = wr;
                end
                default: error = 1'b1;
            endcase
        end else if (ctr_hit) begin
            for (int c = 0; c < NumCounters; c++) begin
                if (32'(ctr_idx) == 32'(c)) begin
                    case (ctr_off)
                        PerfCtrlOff: begin
                            rdata      = 32'(ctrl_q[c]);
                            wr_ctrl[c] = wr;
                        end
                        PerfSelOff: begin
                            rdata     = {sel_q[c].hart_mask, 4'b0, sel_q[c].evt};
                            wr_sel[c] = wr;
                        end
                        PerfLoOff: begin
                            rdata    = value_lo[c];
                            wr_lo[c] = wr;
                            snap[c]  = rd;
                        end
                        PerfHiOff: begin
                            rdata    = 32'(shadow[c]);
                            wr_hi[c] = wr;
                        end
                        default: error = 1'b1;
                    endcase
                end
            end
        end else begin
            error = 1'b1;
        end
        if (error || req_write_i) begin
            rdata = '0;
        end
    end

    // Per-counter increment: popcount of the selected event over the masked harts
    always_comb begin
        for (int c = 0; c < NumCounters; c++) begin
            logic [31:0] mask_full;
            logic [15:0] hev;
            mask_full = {mask_hi_q, sel_q[c].hart_mask};
            incr[c]   = '0;
            for (int h = 0; h < NumCores; h++) begin
                hev     = 16'(events_q[h*NumEvents +: NumEvents]);
                incr[c] = incr[c] + IncW'(mask_full[h] & hev[sel_q[c].evt]);
            end
        end
    end

    // Sticky overflow: a new overflow beats a same-cycle write-1-to-clear
    always_comb begin
        ovf_d = ovf_q;
        if (wr_ovf) begin
            ovf_d = ovf_q & ~req_wdata_i[NumCounters-1:0];
        end
        ovf_d = ovf_d | ovf_set;
    end

    for (genvar c = 0; c < NumCounters; c++) begin : gen_counter
        snitch_perf_counter #(
            .Width (CounterWidth),
            .IncW  (IncW)
        ) i_counter (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .ctrl_i     (ctrl_q[c]),
            .incr_i     (incr[c]),
            .wr_lo_i    (wr_lo[c]),
            .wr_hi_i    (wr_hi[c]),
            .wdata_i    (req_wdata_i),
            .snap_i     (snap[c]),
            .value_lo_o (value_lo[c]),
            .shadow_o   (shadow[c]),
            .ovf_o      (ovf_set[c])
        );
    end

    // Event flop and configuration registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            events_q  <= '0;
            ctrl_q    <= '0;
            sel_q     <= '0;
            mask_hi_q <= '0;
            irq_en_q  <= '0;
            ovf_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            events_q <= core_events_i;
            for (int c = 0; c < NumCounters; c++) begin
                if (wr_ctrl[c]) begin
                    ctrl_q[c] <= perf_ctrl_t'(req_wdata_i[1:0]);
                end
                if (wr_sel[c]) begin
                    sel_q[c].hart_mask <= req_wdata_i[31:8] & HartValid[23:0];
                    sel_q[c].evt       <= req_wdata_i[3:0];
                end
            end
            if (wr_mask_hi) begin
                mask_hi_q <= req_wdata_i[7:0] & HartValid[31:24];
            end
            if (wr_irq_en) begin
                irq_en_q <= req_wdata_i[NumCounters-1:0];
            end
            ovf_q <= ovf_d;
            irq_q <= |(ovf_q & irq_en_q);
        end
    end

    // Response register: loaded on acceptance, held until the consumer takes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata;
            rsp_error_q <= error;
        end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_error_o = rsp_error_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_snitch_perf_counters.sv
// tb/tb_snitch_perf_counters.sv - scoreboard bench for the cluster performance counter unit
module tb_snitch_perf_counters;

    localparam int NC   = 8;
    localparam int NCNT = 4;
    localparam int CW   = 48;
    localparam int NE   = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NC*NE-1:0] core_events = '0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [7:0]       req_addr = '0;
    logic [31:0]      req_wdata = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [31:0]      rsp_rdata;
    logic             rsp_error;
    logic             irq;

    always #5 clk = ~clk;

    snitch_perf_counters #(
        .NumCores     (NC),
        .NumCounters  (NCNT),
        .CounterWidth (CW),
        .NumEvents    (NE)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .core_events_i (core_events),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_write_i   (req_write),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_error_o   (rsp_error),
        .irq_o         (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed response is compared against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got data 0x%08h err %0b expected no response", rsp_rdata, rsp_error);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_data"}, rsp_rdata, e.data);
                check({e.name, "_err"}, 32'(rsp_error), 32'(e.err));
            end
        end
    end

    task automatic access(input string name, input logic w, input logic [7:0] a,
                          input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        int n;
        n = 0;
        exp_q.push_back('{name, ed, ee});
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        while (!req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got req_ready 0 expected 1 within 20 cycles", name);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic wr(input string name, input logic [7:0] a, input logic [31:0] d);
        access(name, 1'b1, a, d, 32'h0, 1'b0);
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [31:0] ed);
        access(name, 1'b0, a, 32'h0, ed, 1'b0);
    endtask

    function automatic logic [NC*NE-1:0] ev(input logic [NC-1:0] harts, input int e);
        logic [NC*NE-1:0] r;
        r = '0;
        for (int h = 0; h < NC; h++) begin
            if (harts[h]) r[h*NE + e] = 1'b1;
        end
        return r;
    endfunction

    task automatic strobe(input logic [NC*NE-1:0] v, input int n);
        core_events = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        core_events = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        idle(3);
        check("reset_req_ready", 32'(req_ready), 32'h1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        idle(1);

        rd("reset_ctrl0", 8'h00, 32'h0);
        rd("reset_ovf", 8'hF0, 32'h0);
        rd("reset_sel0", 8'h04, 32'h0);

        // Event index beyond the strobe width and hart mask bits beyond NumCores
        wr("sel3_wr", 8'h34, 32'hFFFF_FF07);
        rd("sel3_mask_clip", 8'h34, 32'h0000_FF07);
        wr("ctrl3_wr", 8'h30, 32'h1);
        wr("maskhi_wr", 8'hF8, 32'hFF);
        rd("maskhi_clip", 8'hF8, 32'h0);
        strobe({(NC*NE){1'b1}}, 2);
        idle(2);
        rd("evt7_no_count", 8'h38, 32'h0);

        // Retired instructions on harts 0..2 for 10 cycles
        wr("sel0_wr", 8'h04, 32'h0000_FF03);
        wr("ctrl0_wr", 8'h00, 32'h1);
        strobe(ev(8'h07, 3), 10);
        idle(2);
        rd("c0_count30", 8'h08, 32'd30);
        rd("c0_hi_zero", 8'h0C, 32'h0);
        rd("c0_no_ovf", 8'hF0, 32'h0);
        rd("ctrl0_rb", 8'h00, 32'h1);

        // Wrap overflow and interrupt timing
        wr("c0_lo_max", 8'h08, 32'hFFFF_FFFE);
        wr("c0_hi_max", 8'h0C, 32'h0000_FFFF);
        wr("irqen_wr", 8'hF4, 32'h1);
        rd("irqen_rb", 8'hF4, 32'h1);
        strobe(ev(8'h01, 3), 2);
        idle(1);
        check("irq_before_ovf", 32'(irq), 32'h0);
        idle(1);
        check("irq_after_ovf", 32'(irq), 32'h1);
        rd("c0_wrap_lo", 8'h08, 32'h0);
        rd("c0_wrap_hi", 8'h0C, 32'h0);
        rd("ovf_c0", 8'hF0, 32'h1);
        wr("ovf_w1c", 8'hF0, 32'h1);
        check("irq_hold_w1c", 32'(irq), 32'h1);
        idle(1);
        check("irq_clear", 32'(irq), 32'h0);
        rd("ovf_cleared", 8'hF0, 32'h0);

        // Saturate mode
        wr("ctrl0_off", 8'h00, 32'h0);
        wr("sel1_wr", 8'h14, 32'h0000_0F03);
        wr("c1_lo", 8'h18, 32'hFFFF_FFFE);
        wr("c1_hi", 8'h1C, 32'h0000_FFFF);
        wr("ctrl1_sat", 8'h10, 32'h3);
        rd("ctrl1_rb", 8'h10, 32'h3);
        strobe(ev(8'h0F, 3), 1);
        idle(2);
        rd("c1_sat_lo", 8'h18, 32'hFFFF_FFFF);
        rd("c1_sat_hi", 8'h1C, 32'h0000_FFFF);
        rd("ovf_c1", 8'hF0, 32'h2);
        check("irq_masked", 32'(irq), 32'h0);
        strobe(ev(8'h0F, 3), 3);
        idle(2);
        rd("c1_sat_hold_lo", 8'h18, 32'hFFFF_FFFF);
        rd("c1_sat_hold_hi", 8'h1C, 32'h0000_FFFF);

        // Write collides with an increment of 3; then coherent high-word read
        wr("sel2_wr", 8'h24, 32'h0000_0703);
        wr("ctrl2_wr", 8'h20, 32'h1);
        core_events = ev(8'h07, 3);
        @(posedge clk);
        #1;
        core_events = '0;
        wr("c2_lo_collide", 8'h28, 32'd5);
        idle(2);
        rd("c2_write_wins", 8'h28, 32'd5);
        wr("c2_hi_set", 8'h2C, 32'h1);
        wr("c2_lo_set", 8'h28, 32'hFFFF_FFF0);
        rd("c2_lo_snap", 8'h28, 32'hFFFF_FFF0);
        strobe(ev(8'h01, 3), 40);
        idle(2);
        rd("c2_hi_shadow", 8'h2C, 32'h1);
        rd("c2_lo_after", 8'h28, 32'h0000_0018);
        rd("c2_hi_after", 8'h2C, 32'h2);

        // Unmapped addresses and a stalled response
        wr("unmapped_wr_fc", 8'hFC, 32'hFFFF_FFFF);
        exp_q[exp_q.size()-1].err = 1'b1;
        rsp_ready = 1'b0;
        access("unmapped_rd_44", 1'b0, 8'h44, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'h1);
            check("stall_rsp_error", 32'(rsp_error), 32'h1);
            check("stall_rsp_rdata", rsp_rdata, 32'h0);
            check("stall_req_ready", 32'(req_ready), 32'h0);
            idle(1);
        end
        rsp_ready = 1'b1;
        idle(2);

        // Reset with a response pending
        rsp_ready = 1'b0;
        access("pending_before_reset", 1'b0, 8'h28, 32'h0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_irq", 32'(irq), 32'h0);
        exp_q.delete();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        rd("post_rst_c2_shadow", 8'h2C, 32'h0);
        rd("post_rst_c1_lo", 8'h18, 32'h0);
        rd("post_rst_c1_hi", 8'h1C, 32'h0);
        rd("post_rst_c2_lo", 8'h28, 32'h0);
        rd("post_rst_ovf", 8'hF0, 32'h0);
        rd("post_rst_ctrl1", 8'h10, 32'h0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
